fpu_shared_arbiter: RTL

Round-robin arbiter and sequencer that shares one `fpu_core` instance among `NUM_REQ` requesters. It registers a granted request and drives the core for an issue cycle followed by a complete cycle. During the complete cycle it holds OP/RM/operands, because the core's normalizer and F2I path read them live. It then returns the result and flags to the granted requester with a one-cycle valid pulse. It sits between the requesters' FP issue logic and `fpu_core`.

---
 rtl/fpu_shared_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fpu_shared_arbiter.sv
// Round-robin arbiter/sequencer that time-shares one fpu_core among NUM_REQ requesters.
// Each granted op runs an ISSUE cycle then a COMPLETE cycle; the result returns with a one-cycle valid pulse.
package fpu_defs;
  parameter int C_OP  = 32;
  parameter int C_RM  = 3;
  parameter int C_CMD = 4;

  parameter logic [C_CMD-1:0] C_FPU_ADD_CMD = 4'h0;
  parameter logic [C_CMD-1:0] C_FPU_SUB_CMD = 4'h1;
  parameter logic [C_CMD-1:0] C_FPU_MUL_CMD = 4'h2;
  parameter logic [C_CMD-1:0] C_FPU_DIV_CMD = 4'h3;
  parameter logic [C_CMD-1:0] C_FPU_I2F_CMD = 4'h4;
  parameter logic [C_CMD-1:0] C_FPU_F2I_CMD = 4'h5;
endpackage

module fpu_shared_arbiter
  import fpu_defs::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RBI,
  input  logic [NUM_REQ-1:0]             Req_SI,
  output logic [NUM_REQ-1:0]             Gnt_SO,
  input  logic [NUM_REQ-1:0][C_OP-1:0]   Operand_a_DI,
  input  logic [NUM_REQ-1:0][C_OP-1:0]   Operand_b_DI,
  input  logic [NUM_REQ-1:0][C_RM-1:0]   RM_SI,
  input  logic [NUM_REQ-1:0][C_CMD-1:0]  OP_SI,
  output logic [NUM_REQ-1:0]             Valid_SO,
  output logic [C_OP-1:0]                Result_DO,
  output logic [5:0]                     Flags_DO,
  output logic                           Busy_SO,
  output logic                           Fpu_Enable_SO,
  output logic                           Fpu_Stall_SO,
  output logic [C_OP-1:0]                Fpu_Operand_a_DO,
  output logic [C_OP-1:0]                Fpu_Operand_b_DO,
  output logic [C_RM-1:0]                Fpu_RM_SO,
  output logic [C_CMD-1:0]               Fpu_OP_SO,
  input  logic [C_OP-1:0]                Fpu_Result_DI,
  input  logic                           Fpu_OF_SI,
  input  logic                           Fpu_UF_SI,
  input  logic                           Fpu_Zero_SI,
  input  logic                           Fpu_IX_SI,
  input  logic                           Fpu_IV_SI,
  input  logic                           Fpu_Inf_SI
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_e;

  typedef struct packed {
    logic [C_OP-1:0]  a;
    logic [C_OP-1:0]  b;
    logic [C_RM-1:0]  rm;
    logic [C_CMD-1:0] op;
    logic [IW-1:0]    owner;
  } issue_t;

  state_e         state_q, state_d;
  logic [IW-1:0]  last_q;
  issue_t         iss_q;
  logic [IW-1:0]  win, cand;
  logic           found, gnt_vld;

  // Rotating priority: scan from last+1 so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_REQ);
      if (!found && Req_SI[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign gnt_vld = Rst_RBI && found && (state_q != ISSUE);

  always_comb begin
    Gnt_SO = '0;
    if (gnt_vld) Gnt_SO[win] = 1'b1;
  end

  always_comb begin
    state_d          = state_q;
    Busy_SO          = 1'b0;
    Fpu_Enable_SO    = 1'b0;
    Fpu_Stall_SO     = 1'b1;
    Fpu_Operand_a_DO = '0;
    Fpu_Operand_b_DO = '0;
    Fpu_RM_SO        = '0;
    Fpu_OP_SO        = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = ISSUE;
      end
      ISSUE: begin
        Busy_SO          = 1'b1;
        Fpu_Enable_SO    = 1'b1;
        Fpu_Stall_SO     = 1'b0;
        Fpu_Operand_a_DO = iss_q.a;
        Fpu_Operand_b_DO = iss_q.b;
        Fpu_RM_SO        = iss_q.rm;
        Fpu_OP_SO        = iss_q.op;
        state_d          = COMPLETE;
      end
      COMPLETE: begin
        // Operands stay live: the normalizer and F2I path read them this cycle.
        Busy_SO          = 1'b1;
        Fpu_Enable_SO    = 1'b1;
        Fpu_Operand_a_DO = iss_q.a;
        Fpu_Operand_b_DO = iss_q.b;
        Fpu_RM_SO        = iss_q.rm;
        Fpu_OP_SO        = iss_q.op;
        state_d          = gnt_vld ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q   <= IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      iss_q     <= '0;
      Valid_SO  <= '0;
      Result_DO <= '0;
      Flags_DO  <= '0;
    end else begin
      state_q  <= state_d;
      Valid_SO <= '0;
      // Capture uses the old owner; a same-cycle grant overwrites iss_q below.
      if (state_q == COMPLETE) begin
        Valid_SO[iss_q.owner] <= 1'b1;
        Result_DO <= Fpu_Result_DI;
        Flags_DO  <= {Fpu_OF_SI, Fpu_UF_SI, Fpu_Zero_SI, Fpu_IX_SI, Fpu_IV_SI, Fpu_Inf_SI};
      end
      if (gnt_vld) begin
        last_q      <= win;
        iss_q.a     <= Operand_a_DI[win];
        iss_q.b     <= Operand_b_DI[win];
        iss_q.rm    <= RM_SI[win];
        iss_q.op    <= OP_SI[win];
        iss_q.owner <= win;
      end
    end
  end

endmodule
